// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU pixel entry layout and FIFO state encoding.
package ppu_pkg;
    localparam int COLOR_W = 2;
    localparam int ATTR_W  = 3;
    typedef struct packed {
        logic [ATTR_W-1:0]  attr;
        logic [COLOR_W-1:0] colour;
    } pixel_t;
    typedef enum logic {RUN, DISCARD} fifo_state_e;
endpackage

// File: rtl/pixel_fifo_ram.sv
// pixel_fifo_ram: entry storage organised as whole rows, one row write and one entry read.
module pixel_fifo_ram #(
    parameter  int ENTRY_W    = 5,
    parameter  int ROW_PIXELS = 8,
    parameter  int DEPTH      = 16,
    localparam int CW         = $clog2(ROW_PIXELS),
    localparam int AW         = $clog2(DEPTH),
    localparam int RW         = ROW_PIXELS * ENTRY_W
) (
    input  logic               clk_in,
    input  logic               we,
    input  logic [AW-CW-1:0]   wrow,
    input  logic [RW-1:0]      wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);
    // Rows always land on ROW_PIXELS-aligned slots, so storage is indexed per row.
    logic [RW-1:0] mem [DEPTH/ROW_PIXELS];
    logic [RW-1:0] rd_row;
    always_ff @(posedge clk_in)
        if (we) mem[wrow] <= wdata;
    assign rd_row = mem[raddr[AW-1:CW]];
    assign rdata  = rd_row[raddr[CW-1:0]*ENTRY_W +: ENTRY_W];
endmodule

// File: rtl/pixel_row_fifo.sv
// pixel_row_fifo: row-push / pixel-pop PPU FIFO with fine-scroll discard and flush.
// Optional FIFO_FLIP_EN adds horizontal row reversal on push.
module pixel_row_fifo #(
    parameter  int COLOR_W    = ppu_pkg::COLOR_W,
    parameter  int ATTR_W     = ppu_pkg::ATTR_W,
    parameter  int ROW_PIXELS = 8,
    parameter  int DEPTH      = 16,
    localparam int ENTRY_W    = COLOR_W + ATTR_W,
    localparam int CW         = $clog2(ROW_PIXELS),
    localparam int OW         = $clog2(DEPTH) + 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          tclk_in,
    input  logic                          flush_in,
    input  logic                          push_valid_in,
    output logic                          push_ready_out,
    input  logic [ROW_PIXELS*ENTRY_W-1:0] push_row_in,
    input  logic                          push_flip_in,
    input  logic                          pop_en_in,
    input  logic                          discard_load_in,
    input  logic [CW-1:0]                 discard_count_in,
    output logic [ENTRY_W-1:0]            pixel_out,
    output logic                          pixel_valid_out,
    output logic [OW-1:0]                 occupancy_out,
    output logic                          empty_out
);
    import ppu_pkg::*;
    localparam int AW = OW - 1;
    localparam int RW = ROW_PIXELS * ENTRY_W;
    fifo_state_e state, state_nx;
    logic [CW-1:0] dcnt, dcnt_nx;
    logic [AW-CW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [ENTRY_W-1:0] rd_data;
    logic [RW-1:0] wr_row;
    logic flush, push, pop, load, emit;
    assign flush          = tclk_in & flush_in;
    assign push           = tclk_in & ~flush_in & push_valid_in & push_ready_out;
    assign pop            = tclk_in & ~flush_in & pop_en_in & ~empty_out;
    assign load           = tclk_in & ~flush_in & discard_load_in;
    assign emit           = pop & (state == RUN);
    assign push_ready_out = occupancy_out <= OW'(DEPTH - ROW_PIXELS);
    assign empty_out      = occupancy_out == '0;
`ifdef FIFO_FLIP_EN
    for (genvar i = 0; i < ROW_PIXELS; i++) begin : g_flip
        assign wr_row[i*ENTRY_W +: ENTRY_W] = push_flip_in ? push_row_in[(ROW_PIXELS-1-i)*ENTRY_W +: ENTRY_W]
                                                           : push_row_in[i*ENTRY_W +: ENTRY_W];
    end
`else
    logic unused_flip;
    assign unused_flip = push_flip_in;
    assign wr_row      = push_row_in;
`endif
    // DISCARD is held exactly while pixels remain to be dropped.
    always_comb begin
        dcnt_nx  = flush ? '0 : load ? discard_count_in : (pop && state == DISCARD) ? dcnt - 1'b1 : dcnt;
        state_nx = (dcnt_nx != '0) ? DISCARD : RUN;
    end
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            state <= RUN;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
        end
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occupancy_out   <= '0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
        end else begin
            pixel_valid_out <= emit;
            if (emit) pixel_out <= rd_data;
            if (flush) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                occupancy_out <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                occupancy_out <= occupancy_out + (push ? OW'(ROW_PIXELS) : OW'(0)) - (pop ? OW'(1) : OW'(0));
            end
        end
    pixel_fifo_ram #(.ENTRY_W(ENTRY_W), .ROW_PIXELS(ROW_PIXELS), .DEPTH(DEPTH)) u_ram (
        .clk_in (clk_in),
        .we     (push),
        .wrow   (wr_ptr),
        .wdata  (wr_row),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );
endmodule
